// File: rtl/aidc_lite_comp_drain.sv
// -----------------------------------------------------------------------------
// aidc_lite_comp_drain
//
// Read side of the compression block buffer. The engine fills a 16 x 64-bit
// buffer with one 128-byte source block. On comp_start_i this block reads the
// buffer back and hands it to the engine as 32-bit words, one word for each
// comp_rden_i pulse, at up to one word per cycle. This revision packs nothing:
// the words leave in buffer order, low half of each entry first.
//
// Two 64-bit holding registers (CUR, NXT) sit between the buffer read port and
// the word output. CUR supplies the current word. NXT takes the next entry as
// soon as it arrives, so one entry is always ready when CUR runs out.
//
// Optional build macro: AIDC_LITE_COMP_DRAIN_HDR_EN
//   When it is defined, the header word 32'hA1DC_0080 is sent before data word
//   0. The header can be read from the first PRIME cycle onward, and a block
//   then takes 33 reads. When it is undefined, a block takes 32 reads.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   comp_start_i  one-cycle pulse: buffer holds a complete block, begin drain
//   comp_ready_o  1 = idle, a start will be accepted
//   comp_rden_i   engine consumes the current word this cycle
//   comp_rdata_o  current word, valid in the same cycle as comp_rden_i
//   buf_rden_o    buffer read enable
//   buf_raddr_o   buffer read address
//   buf_rdata_i   buffer read data, valid one cycle after buf_rden_o
//   err_o         sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module aidc_lite_comp_drain #(
  parameter int BUF_DEPTH = 16,
  parameter int BUF_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              comp_start_i,
  output logic              comp_ready_o,
  input  logic              comp_rden_i,
  output logic [31:0]       comp_rdata_o,
  output logic              buf_rden_o,
  output logic [BUF_AW-1:0] buf_raddr_o,
  input  logic [63:0]       buf_rdata_i,
  output logic              err_o
);

`ifdef AIDC_LITE_COMP_DRAIN_HDR_EN
  localparam int WCNT_W = 6;
`else
  localparam int WCNT_W = 5;
`endif

  // The fetch address needs one extra bit so that "all entries fetched"
  // (faddr == BUF_DEPTH) can be told apart from address 0.
  localparam int                FA_W      = BUF_AW + 1;
  localparam logic [FA_W-1:0]   DEPTH_L   = FA_W'(BUF_DEPTH);
  localparam logic [FA_W-1:0]   FA_ONE    = FA_W'(1);
  localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(2 * BUF_DEPTH - 1
`ifdef AIDC_LITE_COMP_DRAIN_HDR_EN
                                                    + 1
`endif
                                                    );
  localparam logic [31:0]       HDR_WORD  = 32'hA1DC_0080;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t              state_q, state_d;

  logic [63:0]         cur_q, nxt_q;
  logic                cur_vld_q, nxt_vld_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [FA_W-1:0]     faddr_q;
  logic                buf_rden_p0;
  logic [BUF_AW-1:0]   buf_raddr_p0;
  logic                fetch_vld_p1;
  logic [31:0]         hold_q;
  logic                err_q;

  logic                hdr_phase;
  logic                hi_half;
  logic                word_avail;
  logic [31:0]         word_out;
  logic                rd_ok, rd_bad, rd_entry_done, rd_last;
  logic                start_ok, start_bad;
  logic                prime_second, fetch_more, fetch_go;

  function automatic logic [31:0] sel_half(input logic [63:0] entry,
                                           input logic        hi);
    sel_half = hi ? entry[63:32] : entry[31:0];
  endfunction

  // Word decode: which word is current, and whether one can be read now.
`ifdef AIDC_LITE_COMP_DRAIN_HDR_EN
  // wcnt 0 is the header, so data words are shifted up by one and an odd
  // wcnt selects a low half.
  assign hdr_phase = (wcnt_q == '0) && (state_q != IDLE);
  assign hi_half   = ~wcnt_q[0];
`else
  assign hdr_phase = 1'b0;
  assign hi_half   = wcnt_q[0];
`endif

  assign word_avail = hdr_phase || ((state_q == STREAM) && cur_vld_q);
  assign word_out   = hdr_phase ? HDR_WORD : sel_half(cur_q, hi_half);

  // While no word can be read, the output keeps the last word consumed. After
  // a drain this is the final word of the block, and after reset it is zero.
  assign comp_rdata_o = word_avail ? word_out : hold_q;
  assign comp_ready_o = (state_q == IDLE);
  assign buf_rden_o   = buf_rden_p0;
  assign buf_raddr_o  = buf_raddr_p0;
  assign err_o        = err_q;

  assign rd_ok         = comp_rden_i && word_avail;
  assign rd_bad        = comp_rden_i && !word_avail;
  assign rd_entry_done = rd_ok && !hdr_phase && hi_half;
  assign rd_last       = rd_ok && (wcnt_q == LAST_WCNT);

  assign start_ok  = comp_start_i && (state_q == IDLE);
  assign start_bad = comp_start_i && (state_q != IDLE);

  // PRIME reads two entries back to back so that CUR and NXT both fill. After
  // that, each finished entry frees one slot and triggers one more fetch, until
  // all BUF_DEPTH entries have been read.
  assign prime_second = (state_q == PRIME) && (faddr_q == FA_ONE);
  assign fetch_more   = rd_entry_done && !rd_last && (faddr_q < DEPTH_L);
  assign fetch_go     = prime_second || fetch_more;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok)     state_d = PRIME;
      // Entry 0 lands in CUR on this edge, so the first word is valid in the
      // first STREAM cycle.
      PRIME:   if (fetch_vld_p1) state_d = PRIME == PRIME ? STREAM : STREAM;
      STREAM:  if (rd_last)      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Stage p0: buffer read request. Stage p1: the read data arrives from the
  // buffer and goes into CUR or NXT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q        <= '0;
      nxt_q        <= '0;
      cur_vld_q    <= 1'b0;
      nxt_vld_q    <= 1'b0;
      wcnt_q       <= '0;
      faddr_q      <= '0;
      buf_rden_p0  <= 1'b0;
      buf_raddr_p0 <= '0;
      fetch_vld_p1 <= 1'b0;
      hold_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      fetch_vld_p1 <= buf_rden_p0;
      buf_rden_p0  <= 1'b0;

      if (rd_bad || start_bad) err_q <= 1'b1;
      if (rd_ok)               hold_q <= word_out;

      if (start_ok) begin
        buf_rden_p0  <= 1'b1;
        buf_raddr_p0 <= '0;
        faddr_q      <= FA_ONE;
        wcnt_q       <= '0;
        cur_vld_q    <= 1'b0;
        nxt_vld_q    <= 1'b0;
      end else begin
        if (fetch_go) begin
          buf_rden_p0  <= 1'b1;
          buf_raddr_p0 <= faddr_q[BUF_AW-1:0];
          faddr_q      <= faddr_q + 1'b1;
        end

        if (rd_ok) wcnt_q <= rd_last ? '0 : wcnt_q + 1'b1;

        if (rd_last) begin
          cur_vld_q <= 1'b0;
          nxt_vld_q <= 1'b0;
        end else if (rd_entry_done) begin
          // CUR is used up. Refill it from NXT if NXT holds an entry. If not,
          // take the entry arriving this cycle so that no bubble appears.
          if (nxt_vld_q) begin
            cur_q     <= nxt_q;
            cur_vld_q <= 1'b1;
            nxt_vld_q <= fetch_vld_p1;
            if (fetch_vld_p1) nxt_q <= buf_rdata_i;
          end else if (fetch_vld_p1) begin
            cur_q     <= buf_rdata_i;
            cur_vld_q <= 1'b1;
          end else begin
            cur_vld_q <= 1'b0;
          end
        end else if (fetch_vld_p1) begin
          if (cur_vld_q) begin
            nxt_q     <= buf_rdata_i;
            nxt_vld_q <= 1'b1;
          end else begin
            cur_q     <= buf_rdata_i;
            cur_vld_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aidc_lite_comp_drain.sv
module tb_aidc_lite_comp_drain;

`ifdef AIDC_LITE_COMP_DRAIN_HDR_EN
  localparam int NITEMS = 33;
`else
  localparam int NITEMS = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        comp_start_i;
  logic        comp_ready_o;
  logic        comp_rden_i;
  logic [31:0] comp_rdata_o;
  logic        buf_rden_o;
  logic [3:0]  buf_raddr_o;
  logic [63:0] buf_rdata_i = '0;
  logic        err_o;

  logic [63:0] mem [16];
  int          fetch_cnt = 0;
  int          addr_bad  = 0;
  int          idle_rden = 0;
  logic [3:0]  last_addr = '0;

  int total = 0;
  int bad   = 0;
  int base;

  aidc_lite_comp_drain #(.BUF_DEPTH(16), .BUF_AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .comp_start_i (comp_start_i),
    .comp_ready_o (comp_ready_o),
    .comp_rden_i  (comp_rden_i),
    .comp_rdata_o (comp_rdata_o),
    .buf_rden_o   (buf_rden_o),
    .buf_raddr_o  (buf_raddr_o),
    .buf_rdata_i  (buf_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Buffer model: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (buf_rden_o) begin
      buf_rdata_i <= mem[buf_raddr_o];
      fetch_cnt   <= fetch_cnt + 1;
      if (buf_raddr_o != 4'd0 && buf_raddr_o != 4'(last_addr + 4'd1))
        addr_bad <= addr_bad + 1;
      last_addr <= buf_raddr_o;
      if (comp_ready_o) idle_rden <= idle_rden + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_item(input int n, input bit ff);
    int d;
    d = n;
`ifdef AIDC_LITE_COMP_DRAIN_HDR_EN
    if (n == 0) return 32'hA1DC_0080;
    d = n - 1;
`endif
    return ff ? 32'hFFFF_FFFF : 32'(d);
  endfunction

  // Fixed stall pattern, with 5-cycle stalls before words 7 and 21.
  function automatic int gap_of(input int n, input int mode);
    if (mode == 0) return 0;
    if (n == 7 || n == 21) return 5;
    if (n % 3 == 1) return 1;
    if (n % 5 == 2) return 2;
    return 0;
  endfunction

  task automatic fill(input bit ff);
    for (int k = 0; k < 16; k++)
      mem[k] = ff ? 64'hFFFF_FFFF_FFFF_FFFF : {32'(2 * k + 1), 32'(2 * k)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; comp_start_i = 1'b0; comp_rden_i = 1'b0;
    tick(); tick();
    check("rst_ready", {31'b0, comp_ready_o}, 32'd1);
    check("rst_rdata", comp_rdata_o, 32'd0);
    check("rst_rden",  {31'b0, buf_rden_o}, 32'd0);
    check("rst_raddr", {28'b0, buf_raddr_o}, 32'd0);
    check("rst_err",   {31'b0, err_o}, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  // Drives start in cycle S and returns at cycle S+3.
  task automatic start_prime(input bit bad_rd);
    comp_start_i = 1'b1;
    tick();
    comp_start_i = 1'b0;
`ifndef AIDC_LITE_COMP_DRAIN_HDR_EN
    comp_rden_i = bad_rd;
`endif
    check("s1_ready", {31'b0, comp_ready_o}, 32'd0);
    check("s1_rden",  {31'b0, buf_rden_o}, 32'd1);
    check("s1_raddr", {28'b0, buf_raddr_o}, 32'd0);
    tick();
    comp_rden_i = 1'b0;
    check("s2_rden",  {31'b0, buf_rden_o}, 32'd1);
    check("s2_raddr", {28'b0, buf_raddr_o}, 32'd1);
    tick();
  endtask

  task automatic drain(input bit ff, input int gapm, input int start_at);
    for (int n = 0; n < NITEMS; n++) begin
      logic [31:0] e;
      int g;
      e = exp_item(n, ff);
      g = gap_of(n, gapm);
      for (int j = 0; j < g; j++) begin
        comp_rden_i = 1'b0; comp_start_i = 1'b0;
        check("gap_hold", comp_rdata_o, e);
        tick();
      end
      comp_rden_i  = 1'b1;
      comp_start_i = (n == start_at);
      check("word", comp_rdata_o, e);
      if (n == NITEMS - 1) check("ready_last", {31'b0, comp_ready_o}, 32'd0);
      tick();
    end
    comp_rden_i = 1'b0; comp_start_i = 1'b0;
    check("ready_after", {31'b0, comp_ready_o}, 32'd1);
    check("hold_last", comp_rdata_o, exp_item(NITEMS - 1, ff));
  endtask

  task automatic check_fetch(input string tag);
    check(tag, 32'(fetch_cnt - base), 32'd16);
    check("last_addr", {28'b0, last_addr}, 32'd15);
    check("addr_seq",  32'(addr_bad), 32'd0);
    check("idle_rden", 32'(idle_rden), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; comp_start_i = 1'b0; comp_rden_i = 1'b0;
    fill(1'b0);
    do_reset();

    // Back-to-back drain.
    base = fetch_cnt;
    start_prime(1'b0);
    check("s3_rden", {31'b0, buf_rden_o}, 32'd0);
    drain(1'b0, 0, -1);
    tick();
    check("ready_s36", {31'b0, comp_ready_o}, 32'd1);
    check("t1_err", {31'b0, err_o}, 32'd0);
    check_fetch("t1_fetch");

    // Drain with stalls.
    base = fetch_cnt;
    start_prime(1'b0);
    drain(1'b0, 1, -1);
    check("t2_err", {31'b0, err_o}, 32'd0);
    check_fetch("t2_fetch");

    // Early read at S+1.
    base = fetch_cnt;
    start_prime(1'b1);
`ifndef AIDC_LITE_COMP_DRAIN_HDR_EN
    check("t3_err", {31'b0, err_o}, 32'd1);
`endif
    drain(1'b0, 0, -1);
    check_fetch("t3_fetch");

    // Second start during the drain, then a fresh all-ones block.
    do_reset();
    base = fetch_cnt;
    start_prime(1'b0);
    check("t4_err0", {31'b0, err_o}, 32'd0);
    drain(1'b0, 0, 7);
    check("t4_err1", {31'b0, err_o}, 32'd1);
    check_fetch("t4_fetch");
    fill(1'b1);
    tick();
    base = fetch_cnt;
    start_prime(1'b0);
    drain(1'b1, 0, -1);
    check_fetch("t4b_fetch");

    // Reset in the middle of a drain.
    fill(1'b0);
    do_reset();
    start_prime(1'b0);
    for (int n = 0; n < 12; n++) begin
      comp_rden_i = 1'b1;
      check("t5_word", comp_rdata_o, exp_item(n, 1'b0));
      tick();
    end
    comp_rden_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_ready", {31'b0, comp_ready_o}, 32'd1);
    check("t5_rdata", comp_rdata_o, 32'd0);
    check("t5_rden",  {31'b0, buf_rden_o}, 32'd0);
    check("t5_raddr", {28'b0, buf_raddr_o}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t5_ready2", {31'b0, comp_ready_o}, 32'd1);
    base = fetch_cnt;
    start_prime(1'b0);
    // A start in the same cycle as the final read is ignored.
    drain(1'b0, 0, NITEMS - 1);
    check("t5_err", {31'b0, err_o}, 32'd1);
    tick();
    check("t5_stay_idle", {31'b0, comp_ready_o}, 32'd1);
    check("t5_no_fetch", {31'b0, buf_rden_o}, 32'd0);
    check_fetch("t5_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
